// File: rtl/timed_fifo_dispatcher.sv
// ============================================================================
// timed_fifo_dispatcher
// Timestamped FIFO that releases each 128-bit word when the time counter hits it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timed_fifo_dispatcher #(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 64
) (
    input  logic                          CLK100MHZ,
    input  logic                          reset,
    input  logic                          counter_clear,
    input  logic                          counter_run,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [TS_WIDTH-1:0]           wr_time,
    input  logic [127:0]                  wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fill_count,
    output logic                          overflow,
    output logic                          late_error,
    output logic [127:0]                  late_data,
    output logic [TS_WIDTH-1:0]           counter_value,
    output logic                          counter_matched,
    output logic [127:0]                  data_out
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    logic [TS_WIDTH-1:0] r_mem_time [FIFO_DEPTH];
    logic [127:0]        r_mem_data [FIFO_DEPTH];

    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [TS_WIDTH-1:0] r_counter;
    logic                r_overflow;
    logic                r_late_error;
    logic [127:0]        r_late_data;
    logic                r_matched;
    logic [127:0]        r_data_out;

    logic                w_full;
    logic                w_empty;
    logic [TS_WIDTH-1:0] w_head_time;
    logic [127:0]        w_head_data;
    logic                w_eval;
    logic                w_match;
    logic                w_late;
    logic                w_pop;
    logic                w_push;

    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_head_time = r_mem_time[r_rd_ptr[c_ADDR_W-1:0]];
    assign w_head_data = r_mem_data[r_rd_ptr[c_ADDR_W-1:0]];

    // One head decision per cycle; clear and flush both suppress it.
    assign w_eval  = !w_empty && counter_run && !counter_clear && !flush;
    assign w_match = w_eval && (w_head_time == r_counter);
    assign w_late  = w_eval && (w_head_time <  r_counter);
    assign w_pop   = w_match || w_late;
    assign w_push  = wr_en && !w_full && !flush;

    always_ff @(posedge CLK100MHZ) begin
        if (w_push) begin
            r_mem_time[r_wr_ptr[c_ADDR_W-1:0]] <= wr_time;
            r_mem_data[r_wr_ptr[c_ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_counter    <= '0;
            r_overflow   <= 1'b0;
            r_late_error <= 1'b0;
            r_late_data  <= '0;
            r_matched    <= 1'b0;
            r_data_out   <= '0;
        end else begin
            if (counter_clear) begin
                r_counter <= '0;
            end else if (counter_run) begin
                r_counter <= r_counter + 1'b1;
            end

            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end

            // A write against a full FIFO is lost even if a pop frees space on this edge.
            if (counter_clear) begin
                r_overflow <= 1'b0;
            end else if (wr_en && w_full && !flush) begin
                r_overflow <= 1'b1;
            end

            if (counter_clear) begin
                r_late_error <= 1'b0;
            end else if (w_late) begin
                r_late_error <= 1'b1;
            end

            if (w_late) begin
                r_late_data <= w_head_data;
            end

            r_matched <= w_match;
            if (w_match) begin
                r_data_out <= w_head_data;
            end
        end
    end

    assign full            = w_full;
    assign empty           = w_empty;
    assign fill_count      = r_wr_ptr - r_rd_ptr;
    assign overflow        = r_overflow;
    assign late_error      = r_late_error;
    assign late_data       = r_late_data;
    assign counter_value   = r_counter;
    assign counter_matched = r_matched;
    assign data_out        = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_timed_fifo_dispatcher.sv
// ============================================================================
// tb_timed_fifo_dispatcher
// Directed self-checking bench for timed_fifo_dispatcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timed_fifo_dispatcher;

    localparam int FIFO_DEPTH = 16;
    localparam int TS_WIDTH   = 64;

    logic                        CLK100MHZ;
    logic                        reset;
    logic                        counter_clear;
    logic                        counter_run;
    logic                        flush;
    logic                        wr_en;
    logic [TS_WIDTH-1:0]         wr_time;
    logic [127:0]                wr_data;
    logic                        full;
    logic                        empty;
    logic [$clog2(FIFO_DEPTH):0] fill_count;
    logic                        overflow;
    logic                        late_error;
    logic [127:0]                late_data;
    logic [TS_WIDTH-1:0]         counter_value;
    logic                        counter_matched;
    logic [127:0]                data_out;

    int                  checks;
    int                  failures;
    logic [TS_WIDTH-1:0] exp_cnt;

    timed_fifo_dispatcher #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TS_WIDTH   (TS_WIDTH)
    ) dut (
        .CLK100MHZ       (CLK100MHZ),
        .reset           (reset),
        .counter_clear   (counter_clear),
        .counter_run     (counter_run),
        .flush           (flush),
        .wr_en           (wr_en),
        .wr_time         (wr_time),
        .wr_data         (wr_data),
        .full            (full),
        .empty           (empty),
        .fill_count      (fill_count),
        .overflow        (overflow),
        .late_error      (late_error),
        .late_data       (late_data),
        .counter_value   (counter_value),
        .counter_matched (counter_matched),
        .data_out        (data_out)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    // Advances one edge while tracking the expected counter independently.
    task automatic tick;
        logic [TS_WIDTH-1:0] nxt;
        nxt = (reset || counter_clear) ? '0 : (counter_run ? exp_cnt + 1 : exp_cnt);
        @(posedge CLK100MHZ);
        #1;
        exp_cnt = nxt;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_cnt = '0;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || fill_count !== 5'd0) begin
            failures++;
            $display("FAIL reset_fifo: empty=%b full=%b fill=%0d, required 1 0 0", empty, full, fill_count);
        end
        checks++;
        if (overflow !== 1'b0 || late_error !== 1'b0 || counter_matched !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: ovf=%b late=%b match=%b, required 0 0 0", overflow, late_error, counter_matched);
        end
        checks++;
        if (data_out !== 128'd0 || late_data !== 128'd0 || counter_value !== 64'd0) begin
            failures++;
            $display("FAIL reset_data: data_out=%h late_data=%h cnt=%0d, required zeros", data_out, late_data, counter_value);
        end
    endtask

    task automatic test_single_dispatch;
        counter_clear = 1'b1;
        counter_run   = 1'b1;
        tick();
        counter_clear = 1'b0;
        tick();
        tick();
        checks++;
        if (counter_value !== 64'd2) begin
            failures++;
            $display("FAIL counter_run: got %0d, required 2", counter_value);
        end
        wr_en = 1'b1; wr_time = 64'd10; wr_data = 128'hA5;
        tick();
        wr_en = 1'b0;
        while (exp_cnt < 64'd15) begin
            tick();
            checks++;
            if (counter_matched !== (exp_cnt == 64'd11)) begin
                failures++;
                $display("FAIL single_strobe: cnt=%0d matched=%b, required %b", exp_cnt, counter_matched, exp_cnt == 64'd11);
            end
            if (exp_cnt == 64'd11) begin
                checks++;
                if (data_out !== 128'hA5) begin
                    failures++;
                    $display("FAIL single_data: got %h, required a5", data_out);
                end
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL single_empty: got %b, required 1", empty);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_time = 64'(20 + i); wr_data = 128'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        while (exp_cnt < 64'd25) begin
            tick();
            checks++;
            if (counter_matched !== (exp_cnt >= 64'd21 && exp_cnt <= 64'd23)) begin
                failures++;
                $display("FAIL b2b_strobe: cnt=%0d matched=%b", exp_cnt, counter_matched);
            end
            if (exp_cnt >= 64'd21 && exp_cnt <= 64'd23) begin
                checks++;
                if (data_out !== 128'(exp_cnt - 64'd20)) begin
                    failures++;
                    $display("FAIL b2b_data: cnt=%0d got %h, required %h", exp_cnt, data_out, exp_cnt - 64'd20);
                end
            end
        end
        checks++;
        if (late_error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_late: got %b, required 0", late_error);
        end
    endtask

    task automatic test_late;
        while (exp_cnt < 64'd50) tick();
        wr_en = 1'b1; wr_time = 64'd30; wr_data = 128'h7;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (counter_matched !== 1'b0) begin
                failures++;
                $display("FAIL late_strobe: cnt=%0d matched=%b, required 0", exp_cnt, counter_matched);
            end
        end
        checks++;
        if (late_error !== 1'b1 || late_data !== 128'h7) begin
            failures++;
            $display("FAIL late_flag: late=%b data=%h, required 1 7", late_error, late_data);
        end
        counter_clear = 1'b1;
        tick();
        counter_clear = 1'b0;
        checks++;
        if (late_error !== 1'b0 || counter_value !== 64'd0 || late_data !== 128'h7) begin
            failures++;
            $display("FAIL late_clear: late=%b cnt=%0d data=%h, required 0 0 7", late_error, counter_value, late_data);
        end
    endtask

    task automatic test_overflow;
        counter_run = 1'b0;
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            wr_en = 1'b1; wr_time = (i == 0) ? 64'd0 : 64'd100; wr_data = 128'(i + 256);
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1 || fill_count !== 5'd16 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full: full=%b fill=%0d ovf=%b, required 1 16 1", full, fill_count, overflow);
        end
        counter_run = 1'b1;
        wr_en = 1'b1; wr_time = 64'd100; wr_data = 128'hDEAD;
        tick();
        wr_en = 1'b0;
        counter_run = 1'b0;
        checks++;
        if (fill_count !== 5'd15 || full !== 1'b0 || counter_matched !== 1'b1 || data_out !== 128'h100) begin
            failures++;
            $display("FAIL ovf_pop: fill=%0d full=%b match=%b data=%h, required 15 0 1 100", fill_count, full, counter_matched, data_out);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        counter_clear = 1'b1;
        tick();
        counter_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b empty=%b, required 0 1", overflow, empty);
        end
    endtask

    task automatic test_equal_times;
        counter_run = 1'b1;
        wr_en = 1'b1; wr_time = 64'd40; wr_data = 128'h8;
        tick();
        wr_data = 128'h9;
        tick();
        wr_en = 1'b0;
        while (exp_cnt < 64'd44) begin
            tick();
            checks++;
            if (counter_matched !== (exp_cnt == 64'd41)) begin
                failures++;
                $display("FAIL eq_strobe: cnt=%0d matched=%b", exp_cnt, counter_matched);
            end
        end
        checks++;
        if (data_out !== 128'h8 || late_error !== 1'b1 || late_data !== 128'h9 || empty !== 1'b1) begin
            failures++;
            $display("FAIL eq_result: data=%h late=%b late_data=%h empty=%b, required 8 1 9 1", data_out, late_error, late_data, empty);
        end
    endtask

    task automatic test_flush_and_reset;
        logic [TS_WIDTH-1:0] c;
        counter_run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_time = 64'd200; wr_data = 128'(i + 32);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || fill_count !== 5'd0 || counter_matched !== 1'b0) begin
            failures++;
            $display("FAIL flush: empty=%b fill=%0d match=%b, required 1 0 0", empty, fill_count, counter_matched);
        end
        checks++;
        if (late_error !== 1'b1 || data_out !== 128'h8) begin
            failures++;
            $display("FAIL flush_keep: late=%b data=%h, required 1 8", late_error, data_out);
        end

        counter_run = 1'b1;
        c = exp_cnt;
        wr_en = 1'b1; wr_time = c + 64'd3; wr_data = 128'hB1;
        tick();
        wr_time = c + 64'd4; wr_data = 128'hB2;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        checks++;
        if (counter_matched !== 1'b1 || data_out !== 128'hB1 || fill_count !== 5'd1) begin
            failures++;
            $display("FAIL mid_dispatch: match=%b data=%h fill=%0d, required 1 b1 1", counter_matched, data_out, fill_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (empty !== 1'b1 || fill_count !== 5'd0 || counter_matched !== 1'b0 || counter_value !== 64'd0) begin
            failures++;
            $display("FAIL mid_reset_fifo: empty=%b fill=%0d match=%b cnt=%0d, required 1 0 0 0", empty, fill_count, counter_matched, counter_value);
        end
        checks++;
        if (data_out !== 128'd0 || late_error !== 1'b0 || late_data !== 128'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_regs: data=%h late=%b late_data=%h ovf=%b, required zeros", data_out, late_error, late_data, overflow);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        exp_cnt       = '0;
        reset         = 1'b1;
        counter_clear = 1'b0;
        counter_run   = 1'b0;
        flush         = 1'b0;
        wr_en         = 1'b0;
        wr_time       = '0;
        wr_data       = '0;

        test_reset();
        test_single_dispatch();
        test_back_to_back();
        test_late();
        test_overflow();
        test_equal_times();
        test_flush_and_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timed_fifo_dispatcher.md
Name: timed_fifo_dispatcher

Overview:
- Timestamp-driven instruction buffer directly upstream of the GPO core.
- Accepts 128-bit output words, each tagged with a 64-bit timestamp, from the AXI interface module and holds them in a FIFO.
- Runs a free-running 64-bit time counter and, when the head timestamp equals the counter, presents the word on data_out with a one-cycle counter_matched strobe.
- data_out feeds the GPO core's gpo_in; counter_matched feeds the GPO core's counter_matched.

Parameters:
- FIFO_DEPTH, 16, number of entries; power of two, minimum 2.
- TS_WIDTH, 64, width of the timestamp and of the time counter.

Ports:
- CLK100MHZ  input  1  system clock.
- reset  input  1  synchronous, active-high reset; clock CLK100MHZ.
- counter_clear  input  1  zeroes the time counter and clears the sticky errors.
- counter_run  input  1  counter increments while high; matching is enabled only while high.
- flush  input  1  discards all FIFO entries.
- wr_en  input  1  write strobe.
- wr_time  input  TS_WIDTH  timestamp of the entry being written.
- wr_data  input  128  output word of the entry being written.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- fill_count  output  $clog2(FIFO_DEPTH)+1  number of stored entries.
- overflow  output  1  sticky: a write arrived while full.
- late_error  output  1  sticky: a head entry's timestamp had already passed.
- late_data  output  128  word of the most recently dropped late entry.
- counter_value  output  TS_WIDTH  current time counter.
- counter_matched  output  1  one-cycle dispatch strobe.
- data_out  output  128  word last dispatched; held between strobes.

Behaviour:
- Reset: every output is 0 except empty=1. FIFO pointers and counter are 0.
- Counter: on each edge, if counter_clear then counter<=0; else if counter_run then counter<=counter+1, wrapping from 2^TS_WIDTH-1 to 0.
- Head evaluation happens each cycle when the FIFO is non-empty, counter_run=1, counter_clear=0 and flush=0:
  - Head time == counter (match): on that edge pop the head, set data_out<=head data and counter_matched<=1. counter_matched is therefore high in the cycle where counter_value == head time + 1.
  - Head time < counter, unsigned (late): pop and drop the head, set late_error<=1 and late_data<=head data. counter_matched stays 0.
  - Head time > counter: no action.
- counter_matched is 0 in every cycle other than the one following a match.
- Only one head is evaluated per cycle. Two entries with equal timestamps: the first dispatches and the second is dropped as late on the next cycle.
- Write: accepted when wr_en=1 and full=0 at the edge. When full=1 at the edge, the write is dropped and overflow<=1, even if a pop occurs on the same edge.
- A write and a pop on the same edge are both performed; fill_count is unchanged.
- Write-to-head latency: an entry written into an empty FIFO is evaluated in the cycle after the write edge.
- flush: empties the FIFO on that edge. It has priority over the same-cycle write and head evaluation, which are ignored. It does not affect the counter, data_out or the sticky errors.
- counter_clear: clears overflow and late_error and suppresses head evaluation in that cycle. It does not affect FIFO contents or late_data.
- Reset mid-operation: all state returns to reset values on the next edge; stored entries are lost.
- Storage: FIFO_DEPTH x (TS_WIDTH+128) register array. Read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide.
  - full when the pointer MSBs differ and the remaining bits are equal.
  - empty when the pointers are equal.
  - fill_count = wr_ptr - rd_ptr.

Test Plan:
- Reset, then counter_clear, counter_run=1. Write (time=10, data=128'hA5) at counter=2 -> counter_matched=1 only in the cycle counter_value=11; data_out=128'hA5; empty=1 afterwards.
- Write times 20,21,22 with data 1,2,3 -> strobes at counter_value 21,22,23 with data_out 1,2,3; no late_error.
- Counter at 50, write (time=30, data=128'h7) -> no strobe; late_error=1; late_data=128'h7. Then counter_clear -> late_error=0, counter_value=0.
- counter_run=0; write FIFO_DEPTH+1 entries -> full=1, fill_count=16, overflow=1. Next write with a same-edge match pop -> write still dropped; fill_count=15.
- Two entries with time=40 (data 8, then 9) -> data_out=8 with a strobe at counter_value 41; entry 9 dropped; late_error=1; late_data=128'h9.
- Fill with 5 entries, assert flush together with wr_en -> empty=1, fill_count=0, no strobe. Assert reset mid-dispatch -> all outputs 0, empty=1.
